// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Holds the FSM state encoding and address-split width functions.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    // Word-offset field width within a line.
    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: what remains of a 32-bit byte address above index/offset.
    function automatic int tag_w(input int num_lines, input int line_words);
        return 30 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Data store of the instruction cache: DEPTH x 32 words.
// Ports: clock; we/waddr/wdata synchronous write; raddr/rdata async read.
module icache_data_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Ports: clock, reset (sync, active-high); fetch side icache_addr,
//   icache_data, icache_rdy; refill side mem_addr, mem_req, mem_data,
//   mem_rdy. Optional macro ICACHE_FLUSH_EN adds input flush, which
//   invalidates every line (deferred to refill end if a refill is active).
module icache_dm
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_data,
    output logic        icache_rdy,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_data,
    input  logic        mem_rdy
);

    localparam int OFF  = off_w(LINE_WORDS);
    localparam int IDX  = idx_w(NUM_LINES);
    localparam int TAGW = tag_w(NUM_LINES, LINE_WORDS);
    localparam int LNW  = 30 - OFF;

    state_t state;
    state_t next_state;

    logic [OFF-1:0]       beat;
    logic [LNW-1:0]       line_q;
    logic [NUM_LINES-1:0] valid;
    logic [TAGW-1:0]      tag_mem [NUM_LINES];

    logic [OFF-1:0]  off;
    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic [IDX-1:0]  fill_idx;
    logic [TAGW-1:0] fill_tag;

    logic lookup_hit;
    logic miss;
    logic fill_we;
    logic fill_done;
    logic flush_now;
    logic flush_idle;
    logic drop_fill;
    logic [31:0] rd_word;
    logic addr_unused;

    assign off = icache_addr[OFF+1:2];
    assign idx = icache_addr[OFF+IDX+1:OFF+2];
    assign tag = icache_addr[31:OFF+IDX+2];
    assign addr_unused = ^icache_addr[1:0];

    assign fill_idx = line_q[IDX-1:0];
    assign fill_tag = line_q[LNW-1:IDX];

    assign lookup_hit = valid[idx] && (tag_mem[idx] == tag);
    assign miss       = (state == IDLE) && !lookup_hit;
    assign fill_we    = (state == REFILL) && mem_rdy;
    assign fill_done  = fill_we && (beat == '1);

`ifdef ICACHE_FLUSH_EN
    logic flush_pend;

    assign flush_now  = flush;
    assign flush_idle = (state == IDLE) && flush;
    // A flush seen at any point of the refill discards the new line too.
    assign drop_fill  = flush_pend || flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else if (fill_done) begin
            flush_pend <= 1'b0;
        end else if ((state == REFILL) && flush) begin
            flush_pend <= 1'b1;
        end
    end
`else
    assign flush_now  = 1'b0;
    assign flush_idle = 1'b0;
    assign drop_fill  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (miss) next_state = REFILL;
            REFILL:  if (fill_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        icache_rdy = (state == IDLE) && lookup_hit && !flush_now;
        icache_data = rd_word;
        mem_req  = (state == REFILL);
        mem_addr = '0;
        if (state == REFILL) begin
            mem_addr = {line_q, beat, 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat   <= '0;
            line_q <= '0;
        end else if (miss) begin
            beat   <= '0;
            line_q <= icache_addr[31:OFF+2];
        end else if (fill_we) begin
            beat <= beat + 1'b1;
        end
    end

    // Valid and tag change only on the final beat, so a half-filled
    // line is never observable under either its old or new tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else if (flush_idle) begin
            valid <= '0;
        end else if (fill_done) begin
            if (drop_fill) begin
                valid <= '0;
            end else begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && fill_done) begin
            tag_mem[fill_idx] <= fill_tag;
        end
    end

    icache_data_ram #(
        .DEPTH (NUM_LINES * LINE_WORDS),
        .AW    (IDX + OFF)
    ) u_ram (
        .clock (clock),
        .we    (fill_we),
        .waddr ({fill_idx, beat}),
        .wdata (mem_data),
        .raddr ({idx, off}),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (64 lines x 4 words).
// Backing memory returns addr ^ 0xA5A5A5A5.
module tb_icache_dm;

    logic        clock;
    logic        reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_rdy;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_data;
    logic        mem_rdy;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    int n_vec;
    int n_bad;
    int wr_cnt;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    icache_dm dut (
        .clock       (clock),
        .reset       (reset),
`ifdef ICACHE_FLUSH_EN
        .flush       (flush),
`endif
        .icache_addr (icache_addr),
        .icache_data (icache_data),
        .icache_rdy  (icache_rdy),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_data    (mem_data),
        .mem_rdy     (mem_rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_data = mem_addr ^ PAT;

    always @(posedge clock) begin
        if (mem_req && mem_rdy) wr_cnt = wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Called in the miss cycle with icache_addr = a and mem_rdy = 1.
    task automatic fill(input logic [31:0] base, input logic [31:0] a);
        check("miss_rdy", {31'b0, icache_rdy}, 32'd0);
        check("miss_req", {31'b0, mem_req}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            step();
            check("beat_req", {31'b0, mem_req}, 32'd1);
            check("beat_addr", mem_addr, base + 32'(4 * b));
            check("beat_rdy", {31'b0, icache_rdy}, 32'd0);
        end
        step();
        check("fill_hit", {31'b0, icache_rdy}, 32'd1);
        check("fill_data", icache_data, a ^ PAT);
        check("fill_req", {31'b0, mem_req}, 32'd0);
    endtask

    initial begin
        int beats;
        n_vec = 0;
        n_bad = 0;
        wr_cnt = 0;
        reset = 1'b1;
        icache_addr = 32'h0;
        mem_rdy = 1'b1;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        step();
        step();
        check("rst_rdy", {31'b0, icache_rdy}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_maddr", mem_addr, 32'h0);

        // Cold miss on 0x100 and full refill.
        reset = 1'b0;
        icache_addr = 32'h100;
        #1;
        fill(32'h100, 32'h100);
        check("hit_100", icache_data, 32'hA5A5A4A5);

        icache_addr = 32'h108;
        #1;
        check("hit_108_rdy", {31'b0, icache_rdy}, 32'd1);
        check("hit_108", icache_data, 32'hA5A5A4AD);
        step();
        icache_addr = 32'h10C;
        #1;
        check("hit_10c_rdy", {31'b0, icache_rdy}, 32'd1);
        check("hit_10c", icache_data, 32'hA5A5A4A9);
        check("hit_10c_req", {31'b0, mem_req}, 32'd0);

        // Conflict: same index, different tag evicts 0x100.
        step();
        icache_addr = 32'h500;
        #1;
        fill(32'h500, 32'h500);
        check("hit_500", icache_data, 32'hA5A5A0A5);
        icache_addr = 32'h104;
        #1;
        check("evict_100", {31'b0, icache_rdy}, 32'd0);
        fill(32'h100, 32'h104);

        // Miss with mem_rdy pulsed one cycle in three.
        step();
        icache_addr = 32'h308;
        mem_rdy = 1'b0;
        wr_cnt = 0;
        #1;
        check("slow_miss", {31'b0, icache_rdy}, 32'd0);
        beats = 0;
        for (int k = 0; k < 40 && beats < 4; k++) begin
            step();
            mem_rdy = (k % 3 == 2);
            #1;
            check("slow_addr", mem_addr, 32'h300 + 32'(4 * beats));
            check("slow_rdy", {31'b0, icache_rdy}, 32'd0);
            if (mem_rdy) beats++;
        end
        check("slow_beats", 32'(beats), 32'd4);
        step();
        mem_rdy = 1'b1;
        #1;
        check("slow_hit", {31'b0, icache_rdy}, 32'd1);
        check("slow_data", icache_data, 32'h308 ^ PAT);
        check("slow_writes", 32'(wr_cnt), 32'd4);

        // Reset on the second beat abandons the refill.
        step();
        icache_addr = 32'h404;
        #1;
        check("abort_miss", {31'b0, icache_rdy}, 32'd0);
        step();
        check("abort_b0", mem_addr, 32'h400);
        step();
        check("abort_b1", mem_addr, 32'h404);
        reset = 1'b1;
        step();
        check("abort_req", {31'b0, mem_req}, 32'd0);
        check("abort_rdy", {31'b0, icache_rdy}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_100", {31'b0, icache_rdy}, 32'd0);
        fill(32'h400, 32'h404);

`ifdef ICACHE_FLUSH_EN
        step();
        icache_addr = 32'h100;
        #1;
        fill(32'h100, 32'h100);
        flush = 1'b1;
        #1;
        check("flush_force", {31'b0, icache_rdy}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        fill(32'h100, 32'h100);

        step();
        icache_addr = 32'h200;
        #1;
        check("fl2_miss", {31'b0, icache_rdy}, 32'd0);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        check("fl2_idle_req", {31'b0, mem_req}, 32'd0);
        check("fl2_dropped", {31'b0, icache_rdy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache feeding the CPU's instruction-fetch port (icache_addr / icache_data / icache_rdy).
- Serves hits combinationally in the same cycle.
- On a miss, refills one whole line from a word-wide backing-memory port, one word per beat, then serves the access.
- Sits between the CPU's fetch side and the instruction memory / bus.

Parameters:
- NUM_LINES, 64: number of cache lines; power of 2, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of 2, at least 2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- icache_addr  in  32  fetch byte address from the CPU; bits [1:0] ignored
- icache_data  out  32  instruction word; valid only while icache_rdy=1
- icache_rdy  out  1  hit: icache_data holds the word at icache_addr this cycle
- mem_addr  out  32  word-aligned backing-memory address of the current refill beat
- mem_req  out  1  refill beat request
- mem_data  in  32  backing-memory read data; sampled when mem_rdy=1
- mem_rdy  in  1  beat accepted, mem_data valid this cycle

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high: it takes effect only at a rising clock edge while reset=1.
- Address split:
  - OFF = log2(LINE_WORDS), IDX = log2(NUM_LINES).
  - word offset = addr[OFF+1:2]; index = addr[OFF+IDX+1:OFF+2]; tag = addr[31:OFF+IDX+2].
- Storage:
  - valid bit per line (flops).
  - tag per line.
  - data words NUM_LINES*LINE_WORDS x 32.
- Reset:
  - All valid bits cleared in one cycle; state goes to IDLE; beat counter = 0.
  - mem_req=0 and mem_addr=0.
  - icache_rdy=0 in every cycle the registered state is not IDLE, and all lines read invalid after a reset edge.
  - Reset during REFILL abandons the refill: no line is installed and mem_req drops the next cycle.
- States: IDLE, REFILL.
- IDLE:
  - icache_rdy = valid[index] && tag match (combinational); icache_data = data[index][offset].
  - On a miss, at the edge: latch line base address {addr[31:OFF+2], OFF+2 zero bits}, clear the beat counter, go to REFILL.
  - mem_req=0 in IDLE.
- REFILL:
  - mem_req=1; mem_addr = line base + 4*beat; icache_rdy=0.
  - mem_addr stays stable until mem_rdy.
  - Each cycle with mem_rdy=1: write mem_data to data[latched index][beat] and increment beat.
  - On the beat with beat==LINE_WORDS-1 and mem_rdy=1: set valid and tag of the latched line, go to IDLE. mem_req is 0 from the next cycle.
  - Stalls indefinitely while mem_rdy=0.
- mem_rdy while mem_req=0 is ignored.
- A change of icache_addr during REFILL does not alter the refill. The original line is always completed and installed. The new address is looked up in IDLE afterwards, and may miss again.
- Miss latency with mem_rdy held high: miss detected in cycle 0, beats in cycles 1..LINE_WORDS, hit with icache_rdy=1 in cycle LINE_WORDS+1.
- Refilling a line that is already valid with a different tag overwrites it. The old tag is never visible half-written, because valid/tag update on the final beat only.
  - Caveat: a stale hit on the old tag during refill is impossible, because icache_rdy=0 throughout REFILL.

Optional Feature:
- Macro: ICACHE_FLUSH_EN.
- When defined, adds input port flush (1 bit).
  - flush=1 in IDLE clears all valid bits at the edge; icache_rdy is forced 0 that cycle.
  - flush=1 at any time during REFILL sets a pending flag. On refill completion, all valid bits are cleared, including the just-filled line (not installed). The pending flag clears.
- When not defined: no flush port; valid bits clear only on reset.

Decomposition:
- Package icache_pkg holds:
  - the state encoding (IDLE=0, REFILL=1);
  - localparam functions deriving OFF, IDX and tag width from NUM_LINES / LINE_WORDS.
- One sub-module, icache_data_ram: NUM_LINES*LINE_WORDS x 32, one synchronous write port, one asynchronous read port.
- Tags, valid bits and the FSM stay in icache_dm.

Test Plan:
- Reset, then icache_addr=0x100, mem_rdy=1 always, mem_data=addr^0xA5A5A5A5:
  - icache_rdy=0 in cycles 0..4;
  - mem_addr steps 0x100, 0x104, 0x108, 0x10C;
  - cycle 5: icache_rdy=1, icache_data=0xA5A5A4A5.
- After the fill above, icache_addr=0x108 then 0x10C: icache_rdy=1 same cycle, mem_req stays 0, data = 0xA5A5A4AD / 0xA5A5A4A9.
- Conflict (NUM_LINES=64, LINE_WORDS=4): fetch 0x100, then 0x500 (same index, new tag) → refill of 0x500..0x50C. A following fetch of 0x100 misses again.
- Miss with mem_rdy pulsed 1 cycle in 3: mem_addr holds each beat address until its mem_rdy; exactly 4 data writes; hit on the cycle after the 4th beat.
- Assert reset during the 2nd refill beat, then fetch the same address: icache_rdy=0 and a full 4-beat refill restarts from the line base.
- With ICACHE_FLUSH_EN: fill 0x100, pulse flush in IDLE → next fetch of 0x100 misses. Pulse flush mid-refill of 0x200 → after completion, 0x200 still misses.
